// File: rtl/uart_tx_ctrl_if.sv
// Read-port handshake between the TX-side FIFO and the UART transmit controller.
// The controller is the master: it issues pops and consumes data one cycle later.
interface uart_tx_ctrl_if;
    logic       rd_en;
    logic [8:0] rd_data;
    logic       rd_valid;
    logic       empty;

    modport master (
        output rd_en,
        input  rd_data,
        input  rd_valid,
        input  empty
    );

    modport slave (
        input  rd_en,
        output rd_data,
        output rd_valid,
        output empty
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Drains the TX FIFO and serializes each entry as an 8N1 frame, or as a 10-bit-time
// line break when bit 8 of the entry is set. All outputs come straight from registers.
module uart_tx_ctrl #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic [DIV_WIDTH-1:0] i_clk_div,
    uart_tx_ctrl_if.master       fifo,
    output logic                 o_tx,
    output logic                 o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        START,
        DATA,
        BREAK,
        STOP
    } state_t;

    state_t               state;
    logic                 tx_q;
    logic                 rd_en_q;
    logic                 busy_q;
    logic [7:0]           shift_q;
    logic [DIV_WIDTH-1:0] period_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [3:0]           bit_idx_q;
    logic                 bit_done;

    // Last cycle of the current bit time; the period is frozen for the whole frame.
    assign bit_done = (cnt_q == period_q - DIV_WIDTH'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            tx_q      <= 1'b1;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            period_q  <= DIV_WIDTH'(1);
            cnt_q     <= '0;
            bit_idx_q <= '0;
        end else begin
            rd_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (i_enable && !fifo.empty) begin
                        state   <= FETCH;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (fifo.rd_valid) begin
                        shift_q   <= fifo.rd_data[7:0];
                        period_q  <= (i_clk_div == '0) ? DIV_WIDTH'(1) : i_clk_div;
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        state     <= fifo.rd_data[8] ? BREAK : START;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        cnt_q     <= '0;
                        tx_q      <= shift_q[0];
                        bit_idx_q <= '0;
                        state     <= DATA;
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                DATA: begin
                    // Shift right so the next bit to send is always at shift_q[1].
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 4'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx_q      <= shift_q[1];
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                BREAK: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 4'd9) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt_q  <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign fifo.rd_en = rd_en_q;
    assign o_tx       = tx_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a queue-based FIFO model feeds the DUT and
// each scenario compares the sampled TX line against a frame built from the 8N1 rules.
module tb_uart_tx_ctrl;

    typedef bit bit_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] clk_div;
    logic        tx;
    logic        busy;

    logic        push_req;
    logic [8:0]  push_data;
    logic        flush_req;
    logic [8:0]  fifo_q[$];
    logic        last_rd_en;
    int          pop_count;
    int          pop_empty_err;
    int          double_pop_err;

    int          checks = 0;
    int          passed = 0;
    bit_q_t      cap_q;
    bit          cap_busy_all;

    uart_tx_ctrl_if fifo_bus ();

    uart_tx_ctrl #(.DIV_WIDTH(16)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_enable  (enable),
        .i_clk_div (clk_div),
        .fifo      (fifo_bus),
        .o_tx      (tx),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: one-cycle read latency, push/flush requests applied at the clock edge.
    always @(posedge clk) begin
        if (flush_req) begin
            fifo_q.delete();
            fifo_bus.rd_valid <= 1'b0;
            fifo_bus.rd_data  <= '0;
            fifo_bus.empty    <= 1'b1;
            last_rd_en        <= 1'b0;
            pop_count         <= 0;
            pop_empty_err     <= 0;
            double_pop_err    <= 0;
        end else begin
            if (fifo_bus.rd_en) pop_count <= pop_count + 1;
            if (fifo_bus.rd_en && fifo_bus.empty) pop_empty_err <= pop_empty_err + 1;
            if (fifo_bus.rd_en && last_rd_en) double_pop_err <= double_pop_err + 1;
            last_rd_en <= fifo_bus.rd_en;
            if (fifo_bus.rd_en && fifo_q.size() > 0) begin
                fifo_bus.rd_data  <= fifo_q[0];
                fifo_bus.rd_valid <= 1'b1;
                fifo_q.delete(0);
            end else begin
                fifo_bus.rd_valid <= 1'b0;
            end
            if (push_req) fifo_q.push_back(push_data);
            fifo_bus.empty <= (fifo_q.size() == 0);
        end
    end

    // Expected line from the pop strobe onward: the WAIT cycle, then the frame itself.
    function automatic bit_q_t model_line(input logic [8:0] entry, input int div);
        bit_q_t q;
        int p;
        q = {};
        p = (div == 0) ? 1 : div;
        q.push_back(1'b1);
        if (entry[8]) begin
            for (int i = 0; i < 10 * p; i++) q.push_back(1'b0);
        end else begin
            for (int i = 0; i < p; i++) q.push_back(1'b0);
            for (int b = 0; b < 8; b++)
                for (int i = 0; i < p; i++) q.push_back(entry[b]);
        end
        for (int i = 0; i < p; i++) q.push_back(1'b1);
        return q;
    endfunction

    function automatic int first_diff(input bit_q_t obs, input bit_q_t exp);
        for (int i = 0; i < obs.size(); i++)
            if (i >= exp.size() || obs[i] != exp[i]) return i;
        return -1;
    endfunction

    task automatic push(input logic [8:0] d);
        @(negedge clk);
        push_req  = 1'b1;
        push_data = d;
        @(negedge clk);
        push_req  = 1'b0;
    endtask

    task automatic wait_pop(input int budget, output int waited);
        waited = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fifo_bus.rd_en) begin
                waited = i + 1;
                break;
            end
        end
    endtask

    task automatic capture(input int n);
        repeat (n) begin
            @(negedge clk);
            cap_q.push_back(tx);
            if (!busy) cap_busy_all = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_req = 1'b1; push_req = 1'b0; push_data = '0;
        enable = 1'b0; clk_div = 16'd4;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) $display("[TB] FAIL reset_tx: got %b expected 1", tx); else passed++;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++;
        if (fifo_bus.rd_en !== 1'b0) $display("[TB] FAIL reset_rd_en: got %b expected 0", fifo_bus.rd_en); else passed++;
        rst = 1'b0; flush_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        bit_q_t exp;
        int waited, idx, pops0;
        clk_div = 16'd4; enable = 1'b1;
        exp = model_line(9'h055, 4);
        pops0 = pop_count;
        push(9'h055);
        wait_pop(20, waited);
        checks++;
        if (waited !== 1) $display("[TB] FAIL basic_pop_latency: got %0d expected 1", waited); else passed++;
        cap_q.delete(); cap_busy_all = 1'b1;
        capture(exp.size());
        idx = first_diff(cap_q, exp);
        checks++;
        if (idx != -1) $display("[TB] FAIL basic_line: cycle %0d got %b expected %b", idx, cap_q[idx], exp[idx]); else passed++;
        checks++;
        if (cap_busy_all !== 1'b1) $display("[TB] FAIL basic_busy: got %b expected 1 throughout", cap_busy_all); else passed++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) $display("[TB] FAIL basic_after: got busy=%b tx=%b expected busy=0 tx=1", busy, tx); else passed++;
        checks++;
        if (pop_count - pops0 !== 1) $display("[TB] FAIL basic_pops: got %0d expected 1", pop_count - pops0); else passed++;
    endtask

    task automatic test_back_to_back();
        bit_q_t exp;
        int waited, idx, pops0;
        clk_div = 16'd2; enable = 1'b0;
        pops0 = pop_count;
        push(9'h0A5);
        push(9'h03C);
        @(negedge clk);
        enable = 1'b1;
        wait_pop(20, waited);
        checks++;
        if (waited !== 1) $display("[TB] FAIL b2b_pop_latency: got %0d expected 1", waited); else passed++;
        exp = model_line(9'h0A5, 2);
        cap_q.delete(); cap_busy_all = 1'b1;
        capture(exp.size());
        idx = first_diff(cap_q, exp);
        checks++;
        if (idx != -1) $display("[TB] FAIL b2b_first: cycle %0d got %b expected %b", idx, cap_q[idx], exp[idx]); else passed++;
        // IDLE and FETCH precede the next frame's WAIT: three high cycles in total.
        exp = model_line(9'h03C, 2);
        exp.push_front(1'b1);
        exp.push_front(1'b1);
        cap_q.delete();
        capture(exp.size());
        idx = first_diff(cap_q, exp);
        checks++;
        if (idx != -1) $display("[TB] FAIL b2b_second: cycle %0d got %b expected %b", idx, cap_q[idx], exp[idx]); else passed++;
        cap_q.delete(); cap_busy_all = 1'b1;
        capture(10);
        checks++;
        if (cap_busy_all !== 1'b0) $display("[TB] FAIL b2b_idle_busy: got busy still high expected low"); else passed++;
        checks++;
        if (cap_q.sum() with (int'(item)) !== 10) $display("[TB] FAIL b2b_idle_tx: got %0d high cycles expected 10", cap_q.sum() with (int'(item))); else passed++;
        checks++;
        if (pop_count - pops0 !== 2) $display("[TB] FAIL b2b_pops: got %0d expected 2", pop_count - pops0); else passed++;
    endtask

    task automatic test_break();
        bit_q_t exp;
        int waited, idx;
        clk_div = 16'd3;
        exp = model_line(9'h1FF, 3);
        push(9'h1FF);
        wait_pop(20, waited);
        cap_q.delete(); cap_busy_all = 1'b1;
        capture(exp.size());
        idx = first_diff(cap_q, exp);
        checks++;
        if (idx != -1) $display("[TB] FAIL break_line: cycle %0d got %b expected %b", idx, cap_q[idx], exp[idx]); else passed++;
        checks++;
        if (cap_busy_all !== 1'b1) $display("[TB] FAIL break_busy: got %b expected 1 throughout", cap_busy_all); else passed++;
    endtask

    task automatic test_div_zero();
        bit_q_t exp;
        int waited, idx;
        clk_div = 16'd0;
        exp = model_line(9'h080, 0);
        push(9'h080);
        wait_pop(20, waited);
        cap_q.delete(); cap_busy_all = 1'b1;
        capture(exp.size());
        idx = first_diff(cap_q, exp);
        checks++;
        if (idx != -1) $display("[TB] FAIL div0_line: cycle %0d got %b expected %b", idx, cap_q[idx], exp[idx]); else passed++;
        checks++;
        if (cap_q[9] !== 1'b1) $display("[TB] FAIL div0_bit7: got %b expected 1 at frame clk 8", cap_q[9]); else passed++;
        checks++;
        if (exp.size() !== 11) $display("[TB] FAIL div0_len: got %0d expected 11", exp.size()); else passed++;
    endtask

    task automatic test_reset_midframe();
        bit_q_t exp;
        int waited, idx, pops0;
        logic [8:0] e;
        clk_div = 16'd4;
        e = {1'b0, 8'($urandom)};
        exp = model_line(e, 4);
        push(e);
        wait_pop(20, waited);
        cap_q.delete(); cap_busy_all = 1'b1;
        capture(17);
        idx = first_diff(cap_q, exp);
        checks++;
        if (idx != -1) $display("[TB] FAIL rstmid_prefix: cycle %0d got %b expected %b", idx, cap_q[idx], exp[idx]); else passed++;
        pops0 = pop_count;
        rst = 1'b1; flush_req = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_bus.rd_en !== 1'b0)
            $display("[TB] FAIL rstmid_state: got tx=%b busy=%b rd_en=%b expected 1 0 0", tx, busy, fifo_bus.rd_en);
        else passed++;
        @(negedge clk);
        rst = 1'b0; flush_req = 1'b0;
        checks++;
        if (pops0 < 1) $display("[TB] FAIL rstmid_pop_seen: got %0d pops expected at least 1", pops0); else passed++;
        e = {1'b0, 8'($urandom)};
        exp = model_line(e, 4);
        push(e);
        wait_pop(20, waited);
        checks++;
        if (waited !== 1) $display("[TB] FAIL rstmid_restart_latency: got %0d expected 1", waited); else passed++;
        cap_q.delete();
        capture(exp.size());
        idx = first_diff(cap_q, exp);
        checks++;
        if (idx != -1) $display("[TB] FAIL rstmid_restart: cycle %0d got %b expected %b", idx, cap_q[idx], exp[idx]); else passed++;
    endtask

    task automatic test_enable();
        bit_q_t exp;
        int waited, idx, pops0, bad;
        logic [8:0] e;
        enable = 1'b0; clk_div = 16'd2;
        e = {1'b0, 8'($urandom)};
        exp = model_line(e, 2);
        pops0 = pop_count;
        push(e);
        push({1'b0, 8'($urandom)});
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_bus.rd_en !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) $display("[TB] FAIL en_blocked: got %0d active cycles expected 0", bad); else passed++;
        enable = 1'b1;
        wait_pop(20, waited);
        checks++;
        if (waited !== 1) $display("[TB] FAIL en_pop_latency: got %0d expected 1", waited); else passed++;
        cap_q.delete(); cap_busy_all = 1'b1;
        capture(6);
        enable = 1'b0;
        capture(exp.size() - 6);
        idx = first_diff(cap_q, exp);
        checks++;
        if (idx != -1) $display("[TB] FAIL en_drop_frame: cycle %0d got %b expected %b", idx, cap_q[idx], exp[idx]); else passed++;
        repeat (20) @(negedge clk);
        checks++;
        if (pop_count - pops0 !== 1) $display("[TB] FAIL en_no_more_pops: got %0d expected 1", pop_count - pops0); else passed++;
        checks++;
        if (fifo_q.size() !== 1) $display("[TB] FAIL en_fifo_left: got %0d expected 1", fifo_q.size()); else passed++;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL en_idle: got tx=%b busy=%b expected 1 0", tx, busy); else passed++;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit_q_t exp;
        int waited, idx, p;
        logic [8:0] e;
        enable = 1'b1;
        for (int n = 0; n < 8; n++) begin
            p = $urandom_range(1, 5);
            clk_div = 16'(p);
            e = {($urandom_range(0, 5) == 0), 8'($urandom)};
            exp = model_line(e, p);
            push(e);
            wait_pop(20, waited);
            checks++;
            if (waited !== 1) $display("[TB] FAIL rand_pop_latency[%0d]: got %0d expected 1", n, waited); else passed++;
            cap_q.delete(); cap_busy_all = 1'b1;
            capture(3);
            // A divisor change mid-frame must not stretch or shrink the bits in flight.
            clk_div = 16'($urandom_range(1, 7));
            capture(exp.size() - 3);
            idx = first_diff(cap_q, exp);
            checks++;
            if (idx != -1)
                $display("[TB] FAIL rand_line[%0d] entry=%h div=%0d: cycle %0d got %b expected %b", n, e, p, idx, cap_q[idx], exp[idx]);
            else passed++;
        end
    endtask

    task automatic test_fifo_protocol();
        checks++;
        if (pop_empty_err !== 0) $display("[TB] FAIL pop_while_empty: got %0d expected 0", pop_empty_err); else passed++;
        checks++;
        if (double_pop_err !== 0) $display("[TB] FAIL pop_outstanding: got %0d expected 0", double_pop_err); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_break();
        test_div_zero();
        test_reset_midframe();
        test_enable();
        test_random();
        test_fifo_protocol();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
